// File: rtl/sram_word_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : sram_word_controller_if
// Description : MEM-stage side of the SRAM word controller. Carries the
//               read/write request, byte address, store data, the last read
//               word and the ready (pipeline un-freeze) indication.
//   rd_en      : read request, held while ready = 0
//   wr_en      : write request, held while ready = 0
//   address    : CPU byte address
//   write_data : store data
//   read_data  : last completed read word
//   ready      : 1 = pipeline may advance, 0 = freeze
//   master     : the pipeline side
//   slave      : the controller side
// Revision    : 1.0 - initial release
// ============================================================================
interface sram_word_controller_if;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    modport master (
        output rd_en, wr_en, address, write_data,
        input  read_data, ready
    );

    modport slave (
        input  rd_en, wr_en, address, write_data,
        output read_data, ready
    );
endinterface
`default_nettype wire

// File: rtl/sram_word_controller.sv
`default_nettype none
// ============================================================================
// Module      : sram_word_controller
// Description : Services 32-bit MEM-stage accesses from a 16-bit asynchronous
//               SRAM as two sequenced half-word accesses (LOW then HIGH).
//               Holds ready low while an access is in flight.
// Ports       :
//   clk         : sole clock, rising edge
//   rst         : synchronous active-high reset
//   bus         : request/response interface (slave modport)
//   sram_addr   : SRAM half-word address {word, half}
//   sram_dq_out : data driven onto the SRAM bus during write phases
//   sram_dq_oe  : 1 while the controller drives the SRAM data bus
//   sram_dq_in  : data returned by the SRAM
//   sram_we_n   : active-low SRAM write strobe
// Revision    : 1.0 - initial release
// ============================================================================
module sram_word_controller #(
    parameter int BASE_ADDR     = 1024,
    parameter int ACCESS_CYCLES = 2,
    parameter int SRAM_ADDR_W   = 18
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    sram_word_controller_if.slave       bus,
    output logic [SRAM_ADDR_W-1:0]      sram_addr,
    output logic [15:0]                 sram_dq_out,
    output logic                        sram_dq_oe,
    input  wire logic [15:0]            sram_dq_in,
    output logic                        sram_we_n
);

    localparam int               c_cnt_w    = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(ACCESS_CYCLES - 1);
    localparam logic [31:0]      c_base     = 32'(BASE_ADDR);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [c_cnt_w-1:0]       r_cnt;
    logic [c_cnt_w-1:0]       w_cnt_next;
    logic                     r_is_write;
    logic                     r_half;
    logic [SRAM_ADDR_W-2:0]   r_word;
    logic [31:0]              r_wdata;
    logic [15:0]              r_rd_low;
    logic [31:0]              r_read_data;
    logic                     w_ready;

    logic                     w_req;
    logic [31:0]              w_offset;
    logic                     w_phase_end;
    logic                     w_in_phase;
    logic                     w_unused_offset;

    assign w_req       = bus.rd_en | bus.wr_en;
    // Byte offset from the SRAM base, wrapping modulo 2^32; bits [1:0] and
    // the word bits above the SRAM range are intentionally discarded.
    assign w_offset    = bus.address - c_base;
    assign w_unused_offset = ^{w_offset[31:SRAM_ADDR_W+1], w_offset[1:0]};
    assign w_phase_end = (r_cnt == c_cnt_last);
    assign w_in_phase  = (r_state == S_LOW) || (r_state == S_HIGH);

    assign bus.ready     = w_ready;
    assign bus.read_data = r_read_data;

    // ------------------------------------------------------------------
    // State register and datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_is_write  <= 1'b0;
            r_half      <= 1'b0;
            r_word      <= '0;
            r_wdata     <= '0;
            r_rd_low    <= '0;
            r_read_data <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;

            // Type, address and store data are frozen for the whole access
            // so input changes while ready = 0 have no effect.
            if (r_state == S_IDLE && w_req) begin
                r_is_write <= bus.wr_en;
                r_word     <= w_offset[SRAM_ADDR_W:2];
                r_wdata    <= bus.write_data;
                r_half     <= 1'b0;
            end

            if (r_state == S_LOW && w_phase_end) begin
                r_half <= 1'b1;
                if (!r_is_write) begin
                    r_rd_low <= sram_dq_in;
                end
            end

            // The low half is staged so read_data only changes once the
            // complete word is available.
            if (r_state == S_HIGH && w_phase_end && !r_is_write) begin
                r_read_data <= {sram_dq_in, r_rd_low};
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state and ready
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_ready      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_next = '0;
                if (w_req) begin
                    w_state_next = S_LOW;
                end else begin
                    w_ready = 1'b1;
                end
            end
            S_LOW: begin
                if (w_phase_end) begin
                    w_state_next = S_HIGH;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + c_cnt_w'(1);
                end
            end
            S_HIGH: begin
                if (w_phase_end) begin
                    w_state_next = S_DONE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + c_cnt_w'(1);
                end
            end
            S_DONE: begin
                w_ready      = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // SRAM pin decode: purely from registered state, so every cycle of a
    // phase presents identical pin values. r_word/r_half keep the address
    // stable in IDLE and DONE.
    // ------------------------------------------------------------------
    always_comb begin
        sram_addr   = {r_word, r_half};
        sram_we_n   = 1'b1;
        sram_dq_oe  = 1'b0;
        sram_dq_out = 16'h0000;
        if (w_in_phase && r_is_write) begin
            sram_we_n   = 1'b0;
            sram_dq_oe  = 1'b1;
            sram_dq_out = r_half ? r_wdata[31:16] : r_wdata[15:0];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_word_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_word_controller
// Description : Self-checking bench for sram_word_controller. Two instances
//               (ACCESS_CYCLES = 2 and 1) share one stimulus source selected
//               by sel; each has its own asynchronous SRAM model. Expected
//               pin activity, latency and read data come from a word-level
//               reference memory kept in the bench.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_word_controller;

    localparam int c_base = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;

    always #5 clk = ~clk;

    sram_word_controller_if bus_a();
    sram_word_controller_if bus_b();

    assign bus_a.rd_en      = rd_en & ~sel;
    assign bus_a.wr_en      = wr_en & ~sel;
    assign bus_a.address    = address;
    assign bus_a.write_data = write_data;
    assign bus_b.rd_en      = rd_en & sel;
    assign bus_b.wr_en      = wr_en & sel;
    assign bus_b.address    = address;
    assign bus_b.write_data = write_data;

    wire [17:0] sram_addr_a, sram_addr_b;
    wire [15:0] dq_out_a, dq_out_b, dq_in_a, dq_in_b;
    wire        oe_a, oe_b, we_n_a, we_n_b;

    sram_word_controller #(.BASE_ADDR(c_base), .ACCESS_CYCLES(2), .SRAM_ADDR_W(18)) u_dut_a (
        .clk(clk), .rst(rst), .bus(bus_a.slave),
        .sram_addr(sram_addr_a), .sram_dq_out(dq_out_a), .sram_dq_oe(oe_a),
        .sram_dq_in(dq_in_a), .sram_we_n(we_n_a)
    );

    sram_word_controller #(.BASE_ADDR(c_base), .ACCESS_CYCLES(1), .SRAM_ADDR_W(18)) u_dut_b (
        .clk(clk), .rst(rst), .bus(bus_b.slave),
        .sram_addr(sram_addr_b), .sram_dq_out(dq_out_b), .sram_dq_oe(oe_b),
        .sram_dq_in(dq_in_b), .sram_we_n(we_n_b)
    );

    // Asynchronous SRAM models (64 half-words, low address bits only)
    logic [15:0] sram_a [0:63] = '{default: 16'h0000};
    logic [15:0] sram_b [0:63] = '{default: 16'h0000};
    int          strobes_a = 0;

    assign dq_in_a = sram_a[sram_addr_a[5:0]];
    assign dq_in_b = sram_b[sram_addr_b[5:0]];

    always @(posedge clk) begin
        if (!we_n_a) begin
            sram_a[sram_addr_a[5:0]] <= dq_out_a;
            strobes_a <= strobes_a + 1;
        end
        if (!we_n_b) sram_b[sram_addr_b[5:0]] <= dq_out_b;
    end

    // Observation of the selected instance
    wire [17:0] o_addr   = sel ? sram_addr_b : sram_addr_a;
    wire [15:0] o_dq_out = sel ? dq_out_b : dq_out_a;
    wire        o_oe     = sel ? oe_b : oe_a;
    wire        o_we_n   = sel ? we_n_b : we_n_a;
    wire        o_ready  = sel ? bus_b.ready : bus_a.ready;
    wire [31:0] o_rd     = sel ? bus_b.read_data : bus_a.read_data;

    // Reference model: word-level memory per instance plus last read word
    logic [15:0] ref_mem [2][64];
    logic [31:0] exp_rd  [2];

    int vectors  = 0;
    int errors   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s (sel=%0d t=%0t): got %h expected %h", tag, sel, $time, got, exp);
        end
    endtask

    // One complete access on the selected instance. With now=1 the request
    // is assumed already applied in the current (IDLE) cycle.
    task automatic access(input logic wr, input logic rd, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit now);
        int          ac;
        logic [31:0] off;
        logic [16:0] word;
        logic [17:0] ha_lo, ha_hi;
        logic        half;
        ac    = sel ? 1 : 2;
        off   = addr - 32'(c_base);
        word  = off[18:2];
        ha_lo = {word, 1'b0};
        ha_hi = {word, 1'b1};
        if (!now) @(negedge clk);
        rd_en = rd; wr_en = wr; address = addr; write_data = wdata;
        #1;
        check("detect_ready", {31'd0, o_ready}, 32'd0);
        check("detect_we_n", {31'd0, o_we_n}, 32'd1);
        for (int c = 1; c <= 2 * ac; c++) begin
            @(negedge clk); #1;
            half = (c > ac);
            check("busy_ready", {31'd0, o_ready}, 32'd0);
            check("phase_addr", {14'd0, o_addr}, {14'd0, word, half});
            check("phase_we_n", {31'd0, o_we_n}, {31'd0, ~wr});
            check("phase_oe", {31'd0, o_oe}, {31'd0, wr});
            check("phase_dq_out", {16'd0, o_dq_out},
                  {16'd0, wr ? (half ? wdata[31:16] : wdata[15:0]) : 16'h0000});
        end
        @(negedge clk); #1;
        if (wr) begin
            ref_mem[sel][ha_lo[5:0]] = wdata[15:0];
            ref_mem[sel][ha_hi[5:0]] = wdata[31:16];
        end else begin
            exp_rd[sel] = {ref_mem[sel][ha_hi[5:0]], ref_mem[sel][ha_lo[5:0]]};
        end
        check("done_ready", {31'd0, o_ready}, 32'd1);
        check("done_we_n", {31'd0, o_we_n}, 32'd1);
        check("done_oe", {31'd0, o_oe}, 32'd0);
        check("done_dq_out", {16'd0, o_dq_out}, 32'd0);
        check("done_addr", {14'd0, o_addr}, {14'd0, ha_hi});
        check("read_data", o_rd, exp_rd[sel]);
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        rd_en = 1'b0; wr_en = 1'b0;
        #1;
        check("idle_ready", {31'd0, o_ready}, 32'd1);
        check("idle_we_n", {31'd0, o_we_n}, 32'd1);
        check("idle_read_data", o_rd, exp_rd[sel]);
    endtask

    task automatic random_run(input int n);
        logic [1:0]  r;
        logic [31:0] addr;
        for (int i = 0; i < n; i++) begin
            r = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0)
                addr = 32'(c_base) - 32'(4 * $urandom_range(1, 2));
            else
                addr = 32'(c_base) + 32'(4 * $urandom_range(0, 31)) + 32'($urandom_range(0, 3));
            if (r == 2'b00) idle_cycle();
            else access(r[1], r[0], addr, $urandom(), 1'b0);
        end
    endtask

    initial begin
        int s0;
        for (int k = 0; k < 64; k++) begin
            ref_mem[0][k] = 16'h0000;
            ref_mem[1][k] = 16'h0000;
        end
        exp_rd[0] = 32'd0;
        exp_rd[1] = 32'd0;

        // Reset held for two cycles with a read pending
        sel = 1'b0; rst = 1'b1; rd_en = 1'b1; wr_en = 1'b0;
        address = 32'd1024; write_data = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("rst_ready", {31'd0, o_ready}, 32'd0);
        check("rst_addr", {14'd0, o_addr}, 32'd0);
        check("rst_dq_out", {16'd0, o_dq_out}, 32'd0);
        check("rst_oe", {31'd0, o_oe}, 32'd0);
        check("rst_we_n", {31'd0, o_we_n}, 32'd1);
        check("rst_read_data", o_rd, 32'd0);
        rst = 1'b0;
        access(1'b0, 1'b1, 32'd1024, 32'd0, 1'b1);

        // Directed accesses, ACCESS_CYCLES = 2
        access(1'b1, 1'b0, 32'd1032, 32'hDEADBEEF, 1'b0);
        check("sram_word4", {16'd0, sram_a[4]}, 32'h0000BEEF);
        check("sram_word5", {16'd0, sram_a[5]}, 32'h0000DEAD);
        access(1'b0, 1'b1, 32'd1032, 32'd0, 1'b0);
        access(1'b1, 1'b1, 32'd1024, 32'h12345678, 1'b0);
        check("both_lo", {16'd0, sram_a[0]}, 32'h00005678);
        check("both_hi", {16'd0, sram_a[1]}, 32'h00001234);
        access(1'b0, 1'b1, 32'd1024, 32'd0, 1'b0);
        idle_cycle();
        random_run(40);
        idle_cycle();

        // Back-to-back on the ACCESS_CYCLES = 1 instance
        sel = 1'b1;
        access(1'b1, 1'b0, 32'd1032, 32'hCAFEF00D, 1'b0);
        access(1'b0, 1'b1, 32'd1032, 32'd0, 1'b0);
        idle_cycle();
        random_run(30);
        idle_cycle();

        // Reset during the HIGH phase of a write on instance A
        sel = 1'b0;
        @(negedge clk);
        wr_en = 1'b1; rd_en = 1'b0; address = 32'd1104; write_data = 32'hA5A55A5A;
        repeat (3) @(negedge clk);
        #1;
        check("pre_rst_high_addr", {14'd0, o_addr}, 32'd41);
        check("pre_rst_we_n", {31'd0, o_we_n}, 32'd0);
        rst = 1'b1; wr_en = 1'b0;
        @(negedge clk); #1;
        s0 = strobes_a;
        exp_rd[0] = 32'd0;
        exp_rd[1] = 32'd0;
        check("midrst_we_n", {31'd0, o_we_n}, 32'd1);
        check("midrst_oe", {31'd0, o_oe}, 32'd0);
        check("midrst_ready", {31'd0, o_ready}, 32'd1);
        check("midrst_read_data", o_rd, 32'd0);
        rst = 1'b0;
        repeat (4) idle_cycle();
        check("midrst_no_strobes", 32'(strobes_a), 32'(s0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
